wb_slave_regfile: RTL and testbench

//  Parametrised Wishbone B4 classic-cycle slave holding NUM_REGS registers of DATA_WIDTH bits.

---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_byte_reg.sv | 57 +++++
 rtl/wb_slave_regfile.sv | 157 +++++++++++++++
 tb/tb_wb_slave_regfile.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the register-bank slaves.
//   wb_slave_state_t : FSM encoding of the classic-cycle slave.
//   WB_BYTE_W        : width of one byte lane.
//   wb_lanes()       : number of byte lanes on a bus of the given width.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_S_IDLE = 2'd0,
        WB_S_WAIT = 2'd1,
        WB_S_RESP = 2'd2
    } wb_slave_state_t;

    localparam int WB_BYTE_W = 8;

    function automatic int wb_lanes(input int data_width);
        return data_width / WB_BYTE_W;
    endfunction

endpackage

// File: rtl/wb_byte_reg.sv
// One DATA_WIDTH register with byte-lane bus writes and a full-width hardware load.
// A bus write in the same cycle as a hardware load wins for the whole register:
// selected lanes take bus data, unselected lanes keep their old value.
// Ports:
//   clk_i      clock
//   rst_i      asynchronous active-low reset, loads RESET_VALUE
//   bus_we_i   bus write commit
//   bus_sel_i  byte-lane enables for the bus write
//   bus_dat_i  bus write data
//   hw_we_i    hardware load strobe
//   hw_dat_i   hardware load data
//   q_o        register contents
module wb_byte_reg
    import wb_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            bus_we_i,
    input  logic [DATA_WIDTH/WB_BYTE_W-1:0] bus_sel_i,
    input  logic [DATA_WIDTH-1:0]           bus_dat_i,
    input  logic                            hw_we_i,
    input  logic [DATA_WIDTH-1:0]           hw_dat_i,
    output logic [DATA_WIDTH-1:0]           q_o
);

    localparam int LANES = wb_lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] val_q;
    logic [DATA_WIDTH-1:0] val_d;

    always_comb begin
        val_d = val_q;
        if (bus_we_i) begin
            for (int b = 0; b < LANES; b++) begin
                if (bus_sel_i[b]) begin
                    val_d[b*WB_BYTE_W +: WB_BYTE_W] = bus_dat_i[b*WB_BYTE_W +: WB_BYTE_W];
                end
            end
        end else if (hw_we_i) begin
            val_d = hw_dat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            val_q <= RESET_VALUE;
        end else begin
            val_q <= val_d;
        end
    end

    assign q_o = val_q;

endmodule

// File: rtl/wb_slave_regfile.sv
// Wishbone B4 classic-cycle slave exposing NUM_REGS registers, with byte-lane
// writes, programmable wait states, read-only masking and a hardware update port.
// Handshake: a request is taken in IDLE when cyc_i&stb_i are high at a rising edge;
// after WAIT_STATES wait cycles the slave terminates it for exactly one cycle with
// ack_o (mapped address) or err_o (unmapped), while the master still holds cyc_i&stb_i.
// The master must keep cyc_i high through the edge that ends the response for a write
// to commit; dropping cyc_i before then abandons the transfer silently.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-low reset
//   adr_i, dat_i, sel_i word address, write data, byte-lane enables
//   we_i, stb_i, cyc_i  write enable, strobe, cycle valid
//   dat_o, ack_o, err_o read data, normal and error termination
//   hw_we_i, hw_dat_i   per-register hardware load strobes and data
//   reg_q_o             all register contents, register r at [r*DATA_WIDTH +: DATA_WIDTH]
//   state_o             current FSM state, for debug observation
module wb_slave_regfile
    import wb_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    NUM_REGS    = 8,
    parameter int                    WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [ADDR_WIDTH-1:0]           adr_i,
    input  logic [DATA_WIDTH-1:0]           dat_i,
    output logic [DATA_WIDTH-1:0]           dat_o,
    input  logic [DATA_WIDTH/WB_BYTE_W-1:0] sel_i,
    input  logic                            we_i,
    input  logic                            stb_i,
    input  logic                            cyc_i,
    output logic                            ack_o,
    output logic                            err_o,
    input  logic [NUM_REGS-1:0]             hw_we_i,
    input  logic [NUM_REGS*DATA_WIDTH-1:0]  hw_dat_i,
    output logic [NUM_REGS*DATA_WIDTH-1:0]  reg_q_o,
    output wb_slave_state_t                 state_o
);

    localparam int         LANES   = wb_lanes(DATA_WIDTH);
    localparam logic [3:0] WS_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    wb_slave_state_t       state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [LANES-1:0]      sel_q, sel_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] dat_o_q, dat_o_d;

    logic [DATA_WIDTH-1:0] reg_val [NUM_REGS];
    logic                  hit;
    logic                  bus_commit;
    logic [ADDR_WIDTH-1:0] rd_adr;
    logic [DATA_WIDTH-1:0] rd_val;

    assign hit = 32'(adr_q) < 32'(NUM_REGS);

    // With no wait states RESP is entered straight from IDLE, so the read
    // address is the one being captured at that same edge.
    always_comb begin
        rd_adr = (state_q == WB_S_IDLE) ? adr_i : adr_q;
        rd_val = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rd_adr == ADDR_WIDTH'(r)) begin
                rd_val = reg_val[r];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        adr_d      = adr_q;
        wdat_d     = wdat_q;
        sel_d      = sel_q;
        we_d       = we_q;
        dat_o_d    = dat_o_q;
        bus_commit = 1'b0;
        case (state_q)
            WB_S_IDLE: begin
                if (cyc_i && stb_i) begin
                    adr_d   = adr_i;
                    wdat_d  = dat_i;
                    sel_d   = sel_i;
                    we_d    = we_i;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_STATES > 0) ? WB_S_WAIT : WB_S_RESP;
                end
            end
            WB_S_WAIT: begin
                if (!cyc_i) begin
                    state_d = WB_S_IDLE;
                end else if (cnt_q == WS_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = WB_S_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WB_S_RESP: begin
                state_d    = WB_S_IDLE;
                bus_commit = cyc_i && we_q && hit;
            end
            default: state_d = WB_S_IDLE;
        endcase
        if (state_d == WB_S_RESP && state_q != WB_S_RESP) begin
            dat_o_d = rd_val;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= WB_S_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            dat_o_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            dat_o_q <= dat_o_d;
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        wb_byte_reg #(
            .DATA_WIDTH (DATA_WIDTH),
            .RESET_VALUE(RESET_VALUE)
        ) u_reg (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .bus_we_i (bus_commit && (adr_q == ADDR_WIDTH'(r)) && !RO_MASK[r]),
            .bus_sel_i(sel_q),
            .bus_dat_i(wdat_q),
            .hw_we_i  (hw_we_i[r]),
            .hw_dat_i (hw_dat_i[r*DATA_WIDTH +: DATA_WIDTH]),
            .q_o      (reg_val[r])
        );
        assign reg_q_o[r*DATA_WIDTH +: DATA_WIDTH] = reg_val[r];
    end

    assign dat_o   = dat_o_q;
    assign ack_o   = (state_q == WB_S_RESP) && hit && cyc_i && stb_i;
    assign err_o   = (state_q == WB_S_RESP) && !hit && cyc_i && stb_i;
    assign state_o = state_q;

endmodule

// File: tb/tb_wb_slave_regfile.sv
// Bench for wb_slave_regfile: instance 0 has no wait states and register 0 read-only,
// instance 1 has three wait states and a non-zero reset value.
module tb_wb_slave_regfile;
    import wb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NR = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst    [2];
    logic             cyc    [2];
    logic             stb    [2];
    logic             we     [2];
    logic [AW-1:0]    adr    [2];
    logic [DW-1:0]    dat    [2];
    logic [3:0]       sel    [2];
    logic [NR-1:0]    hw_we  [2];
    logic [NR*DW-1:0] hw_dat [2];
    logic [DW-1:0]    dato   [2];
    logic             ack    [2];
    logic             err    [2];
    logic [NR*DW-1:0] regq   [2];
    wb_slave_state_t  st     [2];

    wb_slave_regfile #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(0),
        .RESET_VALUE(32'h0), .RO_MASK(8'h01)
    ) dut0 (
        .clk_i(clk), .rst_i(rst[0]), .adr_i(adr[0]), .dat_i(dat[0]), .dat_o(dato[0]),
        .sel_i(sel[0]), .we_i(we[0]), .stb_i(stb[0]), .cyc_i(cyc[0]), .ack_o(ack[0]),
        .err_o(err[0]), .hw_we_i(hw_we[0]), .hw_dat_i(hw_dat[0]), .reg_q_o(regq[0]),
        .state_o(st[0])
    );

    wb_slave_regfile #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(3),
        .RESET_VALUE(32'h0000_1234), .RO_MASK(8'h00)
    ) dut1 (
        .clk_i(clk), .rst_i(rst[1]), .adr_i(adr[1]), .dat_i(dat[1]), .dat_o(dato[1]),
        .sel_i(sel[1]), .we_i(we[1]), .stb_i(stb[1]), .cyc_i(cyc[1]), .ack_o(ack[1]),
        .err_o(err[1]), .hw_we_i(hw_we[1]), .hw_dat_i(hw_dat[1]), .reg_q_o(regq[1]),
        .state_o(st[1])
    );

    int total = 0;
    int bad   = 0;

    function automatic int ws_of(input int k);
        return (k == 0) ? 0 : 3;
    endfunction

    function automatic logic [7:0] ro_of(input int k);
        return (k == 0) ? 8'h01 : 8'h00;
    endfunction

    function automatic logic [DW-1:0] rv_of(input int k);
        return (k == 0) ? 32'h0 : 32'h0000_1234;
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Transaction-level model: a pending request, the number of edges since it was
    // captured, and the register array. Response lasts the cycle after edge capture+ws.
    logic [DW-1:0] mreg  [2][NR];
    bit            mpend [2];
    int            mcnt  [2];
    logic [AW-1:0] madr  [2];
    logic [DW-1:0] mdat  [2];
    logic [DW-1:0] mdato [2];
    logic [3:0]    msel  [2];
    bit            mwe   [2];

    task automatic model_step(input int k);
        logic [DW-1:0] old [NR];
        logic [DW-1:0] v;
        logic [7:0]    ro;
        bit            commit;
        if (rst[k] !== 1'b1) begin
            for (int r = 0; r < NR; r++) mreg[k][r] = rv_of(k);
            mpend[k] = 0;
            mcnt[k]  = 0;
            mdato[k] = '0;
            return;
        end
        for (int r = 0; r < NR; r++) old[r] = mreg[k][r];
        ro     = ro_of(k);
        commit = 0;
        if (mpend[k]) begin
            if (!cyc[k]) begin
                mpend[k] = 0;
            end else if (mcnt[k] == ws_of(k)) begin
                if (madr[k] < NR && mwe[k] && !ro[madr[k][2:0]]) commit = 1;
                mpend[k] = 0;
            end else begin
                mcnt[k]++;
                if (mcnt[k] == ws_of(k))
                    mdato[k] = (madr[k] < NR) ? old[madr[k][2:0]] : '0;
            end
        end else if (cyc[k] && stb[k]) begin
            mpend[k] = 1;
            mcnt[k]  = 0;
            madr[k]  = adr[k];
            mdat[k]  = dat[k];
            msel[k]  = sel[k];
            mwe[k]   = we[k];
            if (ws_of(k) == 0)
                mdato[k] = (adr[k] < NR) ? old[adr[k][2:0]] : '0;
        end
        for (int r = 0; r < NR; r++)
            if (hw_we[k][r]) mreg[k][r] = hw_dat[k][r*DW +: DW];
        if (commit) begin
            v = old[madr[k][2:0]];
            for (int b = 0; b < 4; b++)
                if (msel[k][b]) v[8*b +: 8] = mdat[k][8*b +: 8];
            mreg[k][madr[k][2:0]] = v;
        end
    endtask

    task automatic compare(input int k);
        logic [NR*DW-1:0] expq;
        bit resp, hitm, ea, ee;
        for (int r = 0; r < NR; r++) expq[r*DW +: DW] = mreg[k][r];
        resp = mpend[k] && (mcnt[k] == ws_of(k));
        hitm = madr[k] < NR;
        ea   = resp && hitm && cyc[k] && stb[k];
        ee   = resp && !hitm && cyc[k] && stb[k];
        check($sformatf("ack%0d", k), ack[k], ea);
        check($sformatf("err%0d", k), err[k], ee);
        check($sformatf("regq%0d", k), regq[k], expq);
        if (ea || ee) check($sformatf("dato%0d", k), dato[k], mdato[k]);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(0);
            model_step(1);
            #1;
            compare(0);
            compare(1);
        end
    end

    task automatic xfer(input int k, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] s, input logic [NR-1:0] hwm, input logic [DW-1:0] hwv,
                        output logic [DW-1:0] rd, output bit ga, output bit ge, output int lat);
        @(negedge clk);
        cyc[k] = 1; stb[k] = 1; we[k] = w; adr[k] = a; dat[k] = d; sel[k] = s;
        lat = 0; ga = 0; ge = 0; rd = '0;
        while (lat < 40 && !ga && !ge) begin
            @(posedge clk); #1;
            lat++;
            ga = ack[k];
            ge = err[k];
            rd = dato[k];
        end
        check($sformatf("xfer%0d_resp", k), ga | ge, 1'b1);
        @(negedge clk);
        hw_we[k]  = hwm;
        hw_dat[k] = {NR{hwv}};
        @(negedge clk);
        cyc[k] = 0; stb[k] = 0; we[k] = 0; hw_we[k] = '0;
    endtask

    logic [DW-1:0]    rd;
    bit               ga, ge;
    int               lat, nresp;
    logic [NR*DW-1:0] expv;

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 0; cyc[k] = 0; stb[k] = 0; we[k] = 0; adr[k] = '0;
            dat[k] = '0; sel[k] = '0; hw_we[k] = '0; hw_dat[k] = '0;
        end
        repeat (2) @(negedge clk);
        check("rst_regq0", regq[0], '0);
        check("rst_ack0", ack[0], 1'b0);
        check("rst_err0", err[0], 1'b0);
        check("rst_dato0", dato[0], '0);
        check("rst_regq1", regq[1], {NR{32'h0000_1234}});
        rst[0] = 1; rst[1] = 1;
        @(negedge clk);

        // Full write then readback, zero wait states.
        xfer(0, 1, 8'd2, 32'hDEADBEEF, 4'hF, '0, '0, rd, ga, ge, lat);
        check("wr2_ack", ga, 1'b1);
        check("wr2_lat", lat, 1);
        xfer(0, 0, 8'd2, '0, 4'h0, '0, '0, rd, ga, ge, lat);
        check("rd2_lat", lat, 1);
        check("rd2_dat", rd, 32'hDEADBEEF);
        check("rd2_slice", regq[0][2*DW +: DW], 32'hDEADBEEF);

        // Partial byte-lane write.
        xfer(0, 1, 8'd2, 32'h11223344, 4'b0101, '0, '0, rd, ga, ge, lat);
        xfer(0, 0, 8'd2, '0, 4'h0, '0, '0, rd, ga, ge, lat);
        check("sel_dat", rd, 32'hDE22BE44);

        // Unmapped address: error termination, nothing changes, read data is zero.
        xfer(0, 1, 8'd8, 32'hFFFFFFFF, 4'hF, '0, '0, rd, ga, ge, lat);
        check("miss_w_err", ge, 1'b1);
        check("miss_w_ack", ga, 1'b0);
        expv = '0;
        expv[2*DW +: DW] = 32'hDE22BE44;
        check("miss_w_regs", regq[0], expv);
        xfer(0, 0, 8'd8, '0, 4'h0, '0, '0, rd, ga, ge, lat);
        check("miss_r_err", ge, 1'b1);
        check("miss_r_dat", rd, '0);

        // Read-only register and the hardware port.
        xfer(0, 1, 8'd0, 32'h5, 4'hF, '0, '0, rd, ga, ge, lat);
        check("ro_w_ack", ga, 1'b1);
        xfer(0, 0, 8'd0, '0, 4'h0, '0, '0, rd, ga, ge, lat);
        check("ro_r_dat", rd, 32'h0);
        @(negedge clk);
        hw_we[0] = 8'h01; hw_dat[0] = {NR{32'h000000A5}};
        @(negedge clk);
        hw_we[0] = '0;
        xfer(0, 0, 8'd0, '0, 4'h0, '0, '0, rd, ga, ge, lat);
        check("hw_r_dat", rd, 32'h000000A5);
        xfer(0, 1, 8'd1, 32'h77, 4'hF, 8'h02, 32'h99, rd, ga, ge, lat);
        xfer(0, 0, 8'd1, '0, 4'h0, '0, '0, rd, ga, ge, lat);
        check("prio_dat", rd, 32'h77);

        // Three wait states.
        xfer(1, 1, 8'd3, 32'hCAFE, 4'hF, '0, '0, rd, ga, ge, lat);
        check("ws_w_lat", lat, 4);
        xfer(1, 0, 8'd3, '0, 4'h0, '0, '0, rd, ga, ge, lat);
        check("ws_r_lat", lat, 4);
        check("ws_r_dat", rd, 32'hCAFE);

        // Abort in WAIT: no response, no write.
        @(negedge clk);
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 8'd4; dat[1] = 32'hBAD; sel[1] = 4'hF;
        repeat (2) @(negedge clk);
        cyc[1] = 0; stb[1] = 0; we[1] = 0;
        nresp = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack[1] || err[1]) nresp++;
        end
        check("abort_resp", nresp, 0);
        xfer(1, 0, 8'd4, '0, 4'h0, '0, '0, rd, ga, ge, lat);
        check("abort_dat", rd, 32'h0000_1234);

        // Reset while the response is being presented.
        @(negedge clk);
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 8'd5; dat[1] = 32'h55; sel[1] = 4'hF;
        ga = 0; lat = 0;
        while (lat < 20 && !ga) begin
            @(posedge clk); #1;
            lat++;
            ga = ack[1];
        end
        check("rstresp_ack", ga, 1'b1);
        @(negedge clk);
        rst[1] = 0;
        #1;
        check("rstresp_fall", ack[1], 1'b0);
        check("rstresp_regs", regq[1], {NR{32'h0000_1234}});
        cyc[1] = 0; stb[1] = 0; we[1] = 0;
        repeat (2) @(negedge clk);
        rst[1] = 1;
        xfer(1, 0, 8'd5, '0, 4'h0, '0, '0, rd, ga, ge, lat);
        check("rstresp_lost", rd, 32'h0000_1234);

        // Random traffic including aborts, misses and hardware loads.
        for (int k = 0; k < 2; k++) begin
            repeat (400) begin
                @(negedge clk);
                cyc[k] = ($urandom_range(0, 9) != 0);
                stb[k] = ($urandom_range(0, 3) != 0);
                we[k]  = 1'($urandom_range(0, 1));
                adr[k] = AW'($urandom_range(0, 9));
                dat[k] = $urandom;
                sel[k] = 4'($urandom_range(0, 15));
                hw_we[k] = ($urandom_range(0, 3) == 0) ? NR'(1 << $urandom_range(0, NR - 1)) : '0;
                for (int r = 0; r < NR; r++) hw_dat[k][r*DW +: DW] = $urandom;
            end
            @(negedge clk);
            cyc[k] = 0; stb[k] = 0; we[k] = 0; hw_we[k] = '0;
            repeat (6) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
